// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encodings, default width and
// a constant clog2 used to size the bit counter.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam int unsigned SA_DEFAULT_WIDTH = 8;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Existing 1-bit full adder cell, reused as the single arithmetic element.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder around one full_adder: one bit pair per clock, LSB first.
// Define SERIAL_ADDER_OVF_EN to add a registered signed-overflow output (ovf).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int unsigned CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               fa_s, fa_co;
  logic               load;

  full_adder u_fa (
    .a_i  (a_sr_q[0]),
    .b_i  (b_sr_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  // The DONE edge also accepts a new start, so adds run back-to-back every
  // WIDTH+1 clocks; the finished result is already registered at that point.
  assign load = start && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (load) begin
          state_d = S_SHIFT;
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_co;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_co;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;
  // On the last step carry_q is the carry into the MSB and fa_co the carry out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == S_SHIFT && cnt_q == CNT_LAST) begin
      ovf_q <= carry_q ^ fa_co;
    end
  end
  assign ovf = ovf_q;
`endif

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): cycle-accurate busy/done/sum checks.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int failures = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf   (ovf),
`endif
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Launch an op (start sampled at next edge), then wait a bounded time for done.
  task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                        input logic ic, input logic [7:0] es, input logic ec);
    int ndone;
    int lat;
    ndone = 0;
    lat = 0;
    start = 1'b1; a = ia; b = ib; cin = ic;
    edge1();
    start = 1'b0; a = ~ia; b = ~ib; cin = ~ic;
    for (int k = 1; k <= 12; k++) begin
      edge1();
      if (done) begin
        ndone++;
        if (lat == 0) lat = k;
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'd8);
    chk({tag, "_ndone"}, 64'(ndone), 64'd1);
    chk({tag, "_sum"}, 64'(sum), 64'(es));
    chk({tag, "_cout"}, 64'(cout), 64'(ec));
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    edge1();
    rst_n = 1'b1;
    edge1();

    // 5A + 3C: track busy/done/sum at every edge E0..E9
    start = 1'b1; a = 8'h5A; b = 8'h3C; cin = 1'b0;
    edge1();                              // E0
    start = 1'b0; a = 8'h00; b = 8'hFF; cin = 1'b1;
    chk("t1_busy_e0", 64'(busy), 64'd1);
    chk("t1_done_e0", 64'(done), 64'd0);
    for (int k = 1; k <= 8; k++) begin
      edge1();
      chk($sformatf("t1_busy_e%0d", k), 64'(busy), 64'd1);
      chk($sformatf("t1_done_e%0d", k), 64'(done), (k == 8) ? 64'd1 : 64'd0);
      chk($sformatf("t1_sum_e%0d", k), 64'(sum), (k == 8) ? 64'h96 : 64'h00);
    end
    chk("t1_cout", 64'(cout), 64'd0);
    edge1();                              // E9
    chk("t1_busy_e9", 64'(busy), 64'd0);
    chk("t1_done_e9", 64'(done), 64'd0);
    chk("t1_sum_hold", 64'(sum), 64'h96);

    run_op("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("ff_00_c1", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    run_op("80_80_c1", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1);
    run_op("12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

    // Start pulse at E3 mid-op must be ignored
    begin
      int nd;
      nd = 0;
      start = 1'b1; a = 8'h5A; b = 8'h3C; cin = 1'b0;
      edge1();                            // E0
      start = 1'b0;
      edge1(); edge1();                   // E1, E2
      start = 1'b1; a = 8'h11; b = 8'h11; cin = 1'b1;
      edge1();                            // E3
      start = 1'b0;
      if (done) nd++;
      for (int k = 4; k <= 12; k++) begin
        edge1();
        if (done) nd++;
      end
      chk("mid_ndone", 64'(nd), 64'd1);
      chk("mid_sum", 64'(sum), 64'h96);
      chk("mid_cout", 64'(cout), 64'd0);
      chk("mid_idle", 64'(busy), 64'd0);
    end

    // Back-to-back: 5A+3C at E0, 01+02 at E9 (the DONE edge)
    start = 1'b1; a = 8'h5A; b = 8'h3C; cin = 1'b0;
    edge1();                              // E0
    start = 1'b0;
    for (int k = 1; k <= 7; k++) edge1();
    start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
    edge1();                              // E8
    chk("b2b_done_e8", 64'(done), 64'd1);
    chk("b2b_sum_e8", 64'(sum), 64'h96);
    edge1();                              // E9
    start = 1'b0; a = 8'hEE; b = 8'hEE;
    for (int k = 9; k <= 16; k++) begin
      if (k > 9) edge1();
      chk($sformatf("b2b_busy_e%0d", k), 64'(busy), 64'd1);
      chk($sformatf("b2b_done_e%0d", k), 64'(done), 64'd0);
      chk($sformatf("b2b_sum_e%0d", k), 64'(sum), 64'h96);
    end
    edge1();                              // E17
    chk("b2b_done_e17", 64'(done), 64'd1);
    chk("b2b_sum_e17", 64'(sum), 64'h03);
    chk("b2b_cout_e17", 64'(cout), 64'd0);
    edge1();

    // Reset mid-operation at E4
    begin
      int nd;
      nd = 0;
      start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
      edge1();                            // E0
      start = 1'b0;
      edge1(); edge1(); edge1();          // E1..E3
      rst_n = 1'b0;
      #1;
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_done", 64'(done), 64'd0);
      chk("mrst_sum", 64'(sum), 64'd0);
      chk("mrst_cout", 64'(cout), 64'd0);
      edge1();
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
        edge1();
        if (done || busy) nd++;
      end
      chk("mrst_no_done", 64'(nd), 64'd0);
      chk("mrst_sum_after", 64'(sum), 64'd0);
    end

`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf_rst", 64'(ovf), 64'd0);
    run_op("7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
    chk("ovf_7f_01", 64'(ovf), 64'd1);
    run_op("ff_01_ovf", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    chk("ovf_ff_01", 64'(ovf), 64'd0);
    run_op("80_80_ovf", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    chk("ovf_80_80", 64'(ovf), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
